// File: rtl/branch_resolve_unit.sv
// In-order branch resolution queue: captures predictions at decode, checks them
// at resolve, strobes predictor updates, and requests a redirect on a mispredict.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dec_valid,
  input  logic [31:0]      dec_pc,
  input  logic [31:0]      dec_target,
  input  logic             dec_prediction,
  input  logic             mem_valid,
  input  logic             mem_taken,
  output logic             branch_mem_sig,
  output logic             actual_branch_decision,
  output logic [31:0]      update_branch_addr,
  output logic             mispredict,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } br_entry_t;

  br_entry_t         fifo_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  br_entry_t         head;
  logic              push, pop, flush;

  logic              sig_q, act_q, mis_q, rv_q, of_q, uf_q;
  logic [31:0]       addr_q, rpc_q;
  logic [CNT_W-1:0]  bc_q, mc_q;

  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  assign pop   = mem_valid & ~fifo_empty;
  assign flush = pop & (head.pred != mem_taken);
  // A push behind a mispredicting branch is wrong-path and silently dropped.
  assign push  = dec_valid & (~fifo_full | pop) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: dec_pc, tgt: dec_target, pred: dec_prediction};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sig_q    <= 1'b0;
      act_q    <= 1'b0;
      mis_q    <= 1'b0;
      rv_q     <= 1'b0;
      addr_q   <= '0;
      rpc_q    <= '0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      bc_q     <= '0;
      mc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sig_q    <= pop;
      mis_q    <= flush;
      rv_q     <= flush;
      if (pop) begin
        act_q  <= mem_taken;
        addr_q <= head.pc;
      end
      if (flush) rpc_q <= mem_taken ? head.tgt : head.pc + 32'd4;
      if (dec_valid && fifo_full && !pop) of_q <= 1'b1;
      if (mem_valid && fifo_empty)        uf_q <= 1'b1;
      if (pop && bc_q != '1)   bc_q <= bc_q + CNT_W'(1);
      if (flush && mc_q != '1) mc_q <= mc_q + CNT_W'(1);
    end
  end

  assign branch_mem_sig         = sig_q;
  assign actual_branch_decision = act_q;
  assign update_branch_addr     = addr_q;
  assign mispredict             = mis_q;
  assign redirect_valid         = rv_q;
  assign redirect_pc            = rpc_q;
  assign err_overflow           = of_q;
  assign err_underflow          = uf_q;
  assign branch_count           = bc_q;
  assign mispredict_count       = mc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against
// a queue-based reference model. Narrow counters make saturation reachable.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk, reset_n;
  logic dec_valid, dec_prediction, mem_valid, mem_taken;
  logic [31:0] dec_pc, dec_target;
  logic branch_mem_sig, actual_branch_decision, mispredict, redirect_valid;
  logic [31:0] update_branch_addr, redirect_pc;
  logic fifo_full, fifo_empty, err_overflow, err_underflow;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_target(dec_target),
    .dec_prediction(dec_prediction), .mem_valid(mem_valid), .mem_taken(mem_taken),
    .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
    .update_branch_addr(update_branch_addr), .mispredict(mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic        e_sig, e_act, e_mis, e_rv, e_of, e_uf;
  logic [31:0] e_addr, e_rpc;
  int          e_bc, e_mc;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_sig = 0; e_act = 0; e_mis = 0; e_rv = 0; e_of = 0; e_uf = 0;
    e_addr = 0; e_rpc = 0; e_bc = 0; e_mc = 0;
  endtask

  // One clock of the reference behaviour, using the inputs applied this cycle.
  task automatic model_step();
    ent_t h;
    logic wrong_path;
    wrong_path = 0;
    e_sig = 0; e_mis = 0; e_rv = 0;
    if (mem_valid) begin
      if (mq.size() == 0) e_uf = 1;
      else begin
        h = mq.pop_front();
        e_sig = 1; e_act = mem_taken; e_addr = h.pc;
        if (e_bc < CMAX) e_bc++;
        if (h.pred != mem_taken) begin
          e_mis = 1; e_rv = 1;
          e_rpc = mem_taken ? h.tgt : h.pc + 32'd4;
          mq.delete();
          wrong_path = 1;
          if (e_mc < CMAX) e_mc++;
        end
      end
    end
    if (dec_valid && !wrong_path) begin
      if (mq.size() < DEPTH) mq.push_back('{dec_pc, dec_target, dec_prediction});
      else e_of = 1;
    end
  endtask

  task automatic check_all(input string p);
    chk({p, "_sig"},   32'(branch_mem_sig), 32'(e_sig));
    chk({p, "_act"},   32'(actual_branch_decision), 32'(e_act));
    chk({p, "_addr"},  update_branch_addr, e_addr);
    chk({p, "_mis"},   32'(mispredict), 32'(e_mis));
    chk({p, "_rv"},    32'(redirect_valid), 32'(e_rv));
    chk({p, "_rpc"},   redirect_pc, e_rpc);
    chk({p, "_full"},  32'(fifo_full), 32'(mq.size() == DEPTH));
    chk({p, "_empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
    chk({p, "_of"},    32'(err_overflow), 32'(e_of));
    chk({p, "_uf"},    32'(err_underflow), 32'(e_uf));
    chk({p, "_bc"},    32'(branch_count), 32'(e_bc));
    chk({p, "_mc"},    32'(mispredict_count), 32'(e_mc));
  endtask

  task automatic step(input string p, input logic dv, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic pred,
                      input logic mv, input logic taken);
    dec_valid = dv; dec_pc = pc; dec_target = tgt; dec_prediction = pred;
    mem_valid = mv; mem_taken = taken;
    @(posedge clk);
    model_step();
    #1;
    check_all(p);
  endtask

  task automatic push(input string p, input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    step(p, 1'b1, pc, tgt, pred, 1'b0, 1'b0);
  endtask

  task automatic pop(input string p, input logic taken);
    step(p, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, taken);
  endtask

  initial begin
    logic dv, mv, pr, tk;
    checks = 0; errors = 0;
    reset_n = 1'b0;
    dec_valid = 0; dec_pc = 0; dec_target = 0; dec_prediction = 0;
    mem_valid = 0; mem_taken = 0;
    model_reset();
    #12;
    check_all("rst");
    reset_n = 1'b1;

    // Correctly predicted taken branch
    push("p032a", 32'h100, 32'h140, 1'b1);
    pop("p032b", 1'b1);
    chk("r032_addr", update_branch_addr, 32'h100);
    chk("r032_bc", 32'(branch_count), 32'd1);
    step("idle1", 0, 0, 0, 0, 0, 0);

    // Underflow on empty queue
    pop("p035", 1'b1);
    chk("r035_uf", 32'(err_underflow), 32'd1);
    chk("r035_sig", 32'(branch_mem_sig), 32'd0);
    chk("r035_bc", 32'(branch_count), 32'd1);

    // Not-taken mispredict flushes the younger entry
    push("p033a", 32'h200, 32'h180, 1'b1);
    push("p033b", 32'h210, 32'h260, 1'b0);
    pop("p033c", 1'b0);
    chk("r033_mis", 32'(mispredict), 32'd1);
    chk("r033_rpc", redirect_pc, 32'h204);
    chk("r033_empty", 32'(fifo_empty), 32'd1);
    pop("p033d", 1'b0);
    chk("r033_nostrobe", 32'(branch_mem_sig), 32'd0);

    // Fill, overflow, then push+pop while full
    for (int i = 0; i < DEPTH; i++) push("p034f", 32'h300 + 32'(i * 16), 32'h400, 1'b1);
    chk("r034_full", 32'(fifo_full), 32'd1);
    push("p034o", 32'h3f0, 32'h400, 1'b1);
    chk("r034_of", 32'(err_overflow), 32'd1);
    chk("r034_stillfull", 32'(fifo_full), 32'd1);
    step("p034pp", 1'b1, 32'h500, 32'h540, 1'b1, 1'b1, 1'b1);
    chk("r034_ppfull", 32'(fifo_full), 32'd1);
    chk("r034_ppaddr", update_branch_addr, 32'h300);
    for (int i = 0; i < DEPTH; i++) pop("p034d", 1'b1);

    // Taken mispredict redirects to target
    push("pt1", 32'h600, 32'h7000, 1'b0);
    pop("pt2", 1'b1);
    chk("rtk_rpc", redirect_pc, 32'h7000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      dv = ($urandom_range(0, 99) < 55);
      mv = ($urandom_range(0, 99) < 40);
      pr = 1'($urandom_range(0, 1));
      if (mq.size() > 0) tk = ($urandom_range(0, 3) == 0) ? ~mq[0].pred : mq[0].pred;
      else tk = 1'($urandom_range(0, 1));
      step("rnd", dv, $urandom, $urandom, pr, mv, tk);
    end
    step("idle2", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) push("p036", 32'h800 + 32'(i * 4), 32'h900, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    reset_n = 1'b1;
    step("post1", 0, 0, 0, 0, 0, 0);
    pop("post2", 1'b1);
    chk("r036_nostrobe", 32'(branch_mem_sig), 32'd0);
    pop("post3", 1'b1);

    // Drive mispredict counter to saturation
    for (int i = 0; i < CMAX + 4; i++) begin
      push("satp", 32'hA00 + 32'(i), 32'hB00, 1'b1);
      pop("satm", 1'b0);
    end
    chk("r037_mc", 32'(mispredict_count), 32'(CMAX));
    chk("r037_bc", 32'(branch_count), 32'(CMAX));

    dec_valid = 0; mem_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of in-flight branch entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the performance counters.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 dec_valid  input  1  a conditional branch is in decode; its prediction is captured this cycle.
REQ-006 dec_pc  input  32  branch instruction address.
REQ-007 dec_target  input  32  computed taken target (pc+offset).
REQ-008 dec_prediction  input  1  predictor output for this branch (1 = taken).
REQ-009 mem_valid  input  1  the oldest in-flight branch resolves this cycle.
REQ-010 mem_taken  input  1  actual outcome of the resolving branch.
REQ-011 branch_mem_sig  output  1  registered one-cycle pulse: predictor update strobe.
REQ-012 actual_branch_decision  output  1  registered actual outcome, valid with branch_mem_sig.
REQ-013 update_branch_addr  output  32  registered pc of the resolved branch, valid with branch_mem_sig.
REQ-014 mispredict  output  1  registered, valid with branch_mem_sig; 1 when the prediction differed from the outcome.
REQ-015 redirect_valid  output  1  registered one-cycle pulse requesting a pipeline flush and fetch redirect.
REQ-016 redirect_pc  output  32  correct fetch address, valid with redirect_valid.
REQ-017 fifo_full / fifo_empty  output  1 each  combinational occupancy flags.
REQ-018 err_overflow / err_underflow  output  1 each  sticky error flags.
REQ-019 branch_count / mispredict_count  output  CNT_W each  performance counters.

Function
REQ-020 In-order FIFO of DEPTH entries {pc, target, prediction}; wrap-around read and write pointers, plus an occupancy count of width log2(DEPTH)+1.
REQ-021 dec_valid with FIFO not full SHALL push one entry; dec_valid when full SHALL drop the push and set err_overflow.
REQ-022 mem_valid with FIFO not empty SHALL pop the head entry; mem_valid when empty SHALL set err_underflow and produce no strobe.
REQ-023 A simultaneous push and pop SHALL both succeed at any occupancy, including full, and SHALL leave the count unchanged.
REQ-024 Latency: the pop in cycle N SHALL produce branch_mem_sig=1 in cycle N+1, with actual_branch_decision=mem_taken, update_branch_addr=head.pc, and mispredict=(head.prediction != mem_taken).
REQ-025 In every other cycle, branch_mem_sig, mispredict and redirect_valid SHALL be 0; the data outputs SHALL hold their last values.
REQ-026 On a mispredict, redirect_valid=1 in cycle N+1, and redirect_pc SHALL be head.target if mem_taken, else head.pc+4 (32-bit wrap).
REQ-027 On a mispredict pop in cycle N, all remaining entries SHALL be discarded (count=0, pointers equal) at the cycle N edge, and any push in the same cycle SHALL be dropped as wrong-path without setting err_overflow.
REQ-028 branch_count SHALL increment on every valid pop, and mispredict_count on every mispredicting pop; both SHALL saturate at all-ones.
REQ-029 The error flags SHALL remain set until reset.

Reset
REQ-030 While reset_n=0 (asynchronous assert, synchronous release): FIFO empty, fifo_empty=1, fifo_full=0, all strobes 0, data outputs 0, counters 0, error flags 0.
REQ-031 A reset asserted while entries are in flight SHALL discard them; no strobe SHALL be emitted for them after release.

Verification
REQ-032 Push pc=0x100, tgt=0x140, pred=1; next cycle mem_valid with taken=1 -> one cycle later branch_mem_sig=1, mispredict=0, redirect_valid=0, update_branch_addr=0x100, branch_count=1.
REQ-033 Push pc=0x200, tgt=0x180, pred=1, then pc=0x210 pred=0; resolve the first with taken=0 -> mispredict=1, redirect_pc=0x204, fifo_empty=1 on the next cycle, and the 0x210 entry never resolves.
REQ-034 Fill to DEPTH=4, then apply dec_valid alone -> err_overflow=1, count stays 4; then push and pop simultaneously -> count stays 4, no error.
REQ-035 mem_valid on an empty FIFO -> err_underflow=1, branch_mem_sig stays 0, counters unchanged.
REQ-036 Push three entries, assert reset_n=0 mid-cycle -> outputs clear immediately; after release fifo_empty=1 and no strobes occur.
REQ-037 Force mispredict_count to all-ones minus one and apply two mispredicting pops -> the counter saturates at 0xFFFF.
